// File: rtl/decoder_pkg.sv
// decoder_pkg: control enums and constants shared by the decoder and the
// multi-cycle sequencer.
//   wb_mux_sel_t : write-back source select driven by the decoder
//   seq_state_t  : core_sequencer FSM states
//   NOP_INSTR    : addi x0,x0,0, instruction register reset value
//   jump_target  : JALR-style target with bit 0 cleared
package decoder_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_DM  = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_mux_sel_t;

  typedef enum logic [2:0] {
    SEQ_FETCH = 3'd0,
    SEQ_EXEC  = 3'd1,
    SEQ_MEM   = 3'd2,
    SEQ_WB    = 3'd3,
    SEQ_IDLE  = 3'd4,
    SEQ_FAULT = 3'd5
  } seq_state_t;

  function automatic logic [31:0] jump_target(input logic [31:0] target);
    return {target[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: instruction and data memory request/acknowledge ports.
//   imem_req/imem_addr  -> fetch request and address (from sequencer)
//   imem_ack/imem_rdata <- fetch completion and instruction (from memory)
//   dmem_req/dmem_we    -> data request and write qualifier (from sequencer)
//   dmem_ack/dmem_rdata <- data completion and load data (from memory)
interface core_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle RV32I control sequencer. Owns the PC, fetches
// and latches instructions, steps them through EXEC / MEM / WB and gates the
// register-file and CSR write strobes to one per retired instruction.
// Ports:
//   clk, reset_n          core clock, async active-low reset
//   mem                   memory request/ack bundle (master side)
//   instr                 latched instruction to the decoder
//   is_load .. next_pc    decoder / branch-unit / ALU status
//   load_data             registered load data
//   pc, pc_plus_4         current PC and its sequential successor
//   rf_we, csr_we         write strobes, WB cycle only
//   halt, idle            stop request / halted indication
//   fault                 sticky misaligned jump/branch target
//   instret               retired instruction count
//
// state     | meaning
// ----------+-------------------------------------------------------
// SEQ_FETCH | imem request at pc until acked, latch instruction
// SEQ_EXEC  | decoder/ALU settle, pick MEM or WB
// SEQ_MEM   | dmem request held until acked, latch load data
// SEQ_WB    | write strobes, PC update, instret, fault check
// SEQ_IDLE  | halted, no requests
// SEQ_FAULT | terminal after misaligned target, left only by reset
module core_sequencer
  import decoder_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = decoder_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     reset_n,
  core_sequencer_if.master         mem,
  output logic [31:0]              instr,
  input  logic                     is_load,
  input  logic                     is_store,
  input  logic                     wb_write_enable,
  input  logic                     csr_enable,
  input  logic                     branch_always,
  input  logic                     branch_instr,
  input  logic                     branch_taken,
  input  logic [31:0]              next_pc,
  output logic [31:0]              load_data,
  output logic [31:0]              pc,
  output logic [31:0]              pc_plus_4,
  output logic                     rf_we,
  output logic                     csr_we,
  input  logic                     halt,
  output logic                     idle,
  output logic                     fault,
  output logic [31:0]              instret
);

  seq_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] instret_q, instret_d;
  logic        fault_q, fault_d;
  logic        dmem_we_q, dmem_we_d;
  // Holds off the first fetch until one edge after reset release so no
  // request is ever visible while reset_n is low.
  logic        run_q;
  logic        taken;
  logic        misaligned;

  assign taken      = branch_always | (branch_instr & branch_taken);
  assign misaligned = taken & next_pc[1];

  assign pc_plus_4     = pc_q + 32'd4;
  assign pc            = pc_q;
  assign instr         = instr_q;
  assign load_data     = load_data_q;
  assign instret       = instret_q;
  assign fault         = fault_q;
  assign mem.imem_addr = pc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SEQ_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      load_data_q <= 32'd0;
      instret_q   <= 32'd0;
      fault_q     <= 1'b0;
      dmem_we_q   <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      load_data_q <= load_data_d;
      instret_q   <= instret_d;
      fault_q     <= fault_d;
      dmem_we_q   <= dmem_we_d;
      run_q       <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    load_data_d  = load_data_q;
    instret_d    = instret_q;
    fault_d      = fault_q;
    dmem_we_d    = dmem_we_q;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    rf_we        = 1'b0;
    csr_we       = 1'b0;
    idle         = 1'b0;

    case (state_q)
      SEQ_FETCH: begin
        mem.imem_req = run_q;
        if (run_q && mem.imem_ack) begin
          instr_d = mem.imem_rdata;
          state_d = SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        // Capture the direction so dmem_we cannot move mid-request.
        dmem_we_d = is_store;
        state_d   = (is_load | is_store) ? SEQ_MEM : SEQ_WB;
      end
      SEQ_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = dmem_we_q;
        if (mem.dmem_ack) begin
          if (!dmem_we_q) load_data_d = mem.dmem_rdata;
          state_d = SEQ_WB;
        end
      end
      SEQ_WB: begin
        if (misaligned) begin
          fault_d = 1'b1;
          state_d = SEQ_FAULT;
        end else begin
          rf_we     = wb_write_enable;
          csr_we    = csr_enable;
          instret_d = instret_q + 32'd1;
          pc_d      = taken ? jump_target(next_pc) : pc_plus_4;
          state_d   = halt ? SEQ_IDLE : SEQ_FETCH;
        end
      end
      SEQ_IDLE: begin
        idle = 1'b1;
        if (!halt) state_d = SEQ_FETCH;
      end
      SEQ_FAULT: begin
      end
      default: state_d = SEQ_FAULT;
    endcase
  end

endmodule
